// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared widths, FSM encoding and host mode constants
// Purpose: common definitions for the data-memory responder slice.
// Contents: DEF_ADDR_W/DEF_DATA_W defaults, state_t burst FSM encoding,
//           MODE_LOAD/MODE_DUMP values for host_mode.
package cpu_pkg;

  localparam int DEF_ADDR_W = 8;
  localparam int DEF_DATA_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DUMP = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic MODE_LOAD = 1'b0;
  localparam logic MODE_DUMP = 1'b1;

endpackage

// File: rtl/dmem_responder_if.sv
// rtl/dmem_responder_if.sv - CPU data bus plus host burst port bundle
// Purpose: groups the CPU load/store bus and the host valid/ready burst port.
// Modports: master = CPU/host side (drives requests, sees responses),
//           slave  = dmem_responder.
interface dmem_responder_if
  import cpu_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
);

  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_dataout;
  logic              d_we;
  logic [DATA_W-1:0] d_datain;
  logic              host_start;
  logic              host_mode;
  logic [ADDR_W-1:0] host_base;
  logic [ADDR_W:0]   host_len;
  logic [DATA_W-1:0] host_wdata;
  logic              host_wvalid;
  logic              host_wready;
  logic [DATA_W-1:0] host_rdata;
  logic              host_rvalid;
  logic              host_rready;
  logic              busy;
  logic              done;

  modport master (
    output d_addr, d_dataout, d_we, host_start, host_mode, host_base,
           host_len, host_wdata, host_wvalid, host_rready,
    input  d_datain, host_wready, host_rdata, host_rvalid, busy, done
  );

  modport slave (
    input  d_addr, d_dataout, d_we, host_start, host_mode, host_base,
           host_len, host_wdata, host_wvalid, host_rready,
    output d_datain, host_wready, host_rdata, host_rvalid, busy, done
  );

endinterface

// File: rtl/dmem_array.sv
// rtl/dmem_array.sv - 2**ADDR_W x DATA_W word array, two read ports, one write port
// Purpose: storage for the data-memory responder.
// Ports: clock/reset; cpu_addr/cpu_we/cpu_wdata/cpu_rdata (async read);
//        host_addr/host_we/host_wdata (write), rd_en/rd_data (registered read).
module dmem_array #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic              cpu_we,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic              host_we,
  input  logic [DATA_W-1:0] host_wdata,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  // Same-cycle read of a location being written returns the old word.
  assign cpu_rdata = mem[cpu_addr];

  // Single write port: the CPU always has priority over the host.
  always_ff @(posedge clock) begin
    if (cpu_we) begin
      mem[cpu_addr] <= cpu_wdata;
    end else if (host_we) begin
      mem[host_addr] <= host_wdata;
    end
  end

  // Dump read register; holds its value whenever no fetch is issued.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[host_addr];
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - zero-wait-state data memory with host load/dump bursts
// Purpose: serves CPU loads/stores and host preload/dump bursts on one array.
// Ports: clock, reset (async, active-high); bus (dmem_responder_if.slave)
//        carrying the CPU data bus, host burst handshakes, busy and done.
module dmem_responder
  import cpu_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input logic              clock,
  input logic              reset,
  dmem_responder_if.slave  bus
);

  localparam logic [ADDR_W:0] CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic              rvalid_q, rvalid_d;
  logic              done_q;
  logic              host_we;
  logic              rd_en;

  dmem_array #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_array (
    .clock      (clock),
    .reset      (reset),
    .cpu_addr   (bus.d_addr),
    .cpu_we     (bus.d_we),
    .cpu_wdata  (bus.d_dataout),
    .cpu_rdata  (bus.d_datain),
    .host_addr  (addr_q),
    .host_we    (host_we),
    .host_wdata (bus.host_wdata),
    .rd_en      (rd_en),
    .rd_data    (bus.host_rdata)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      cnt_q    <= '0;
      rvalid_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      cnt_q    <= cnt_d;
      rvalid_q <= rvalid_d;
      // Pulse lands the cycle after the FSM passes through DONE.
      done_q   <= (state_q == DONE);
    end
  end

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    cnt_d    = cnt_q;
    rvalid_d = rvalid_q;
    host_we  = 1'b0;
    rd_en    = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.host_start) begin
          addr_d = bus.host_base;
          cnt_d  = bus.host_len;
          if (bus.host_len == '0) begin
            state_d = DONE;
          end else begin
            state_d = (bus.host_mode == MODE_DUMP) ? DUMP : LOAD;
          end
        end
      end
      LOAD: begin
        // A CPU store owns the write port, so the host waits that cycle.
        if (bus.host_wvalid && !bus.d_we) begin
          host_we = 1'b1;
          addr_d  = addr_q + 1'b1;
          cnt_d   = cnt_q - 1'b1;
          if (cnt_q == CNT_ONE) begin
            state_d = DONE;
          end
        end
      end
      DUMP: begin
        // cnt_q counts words still to fetch; the output register drains last.
        if ((!rvalid_q || bus.host_rready) && (cnt_q != '0)) begin
          rd_en    = 1'b1;
          rvalid_d = 1'b1;
          addr_d   = addr_q + 1'b1;
          cnt_d    = cnt_q - 1'b1;
        end else if (rvalid_q && bus.host_rready) begin
          rvalid_d = 1'b0;
          state_d  = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.host_wready = (state_q == LOAD) && !bus.d_we;
  assign bus.host_rvalid = rvalid_q;
  assign bus.busy        = (state_q == LOAD) || (state_q == DUMP);
  assign bus.done        = done_q;

endmodule
